// File: rtl/alu_mc_pkg.sv
// Shared opcodes, status bit positions and handshake FSM states for alu_mc.
package alu_mc_pkg;

  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_NOT   = 5'h06;
  localparam logic [4:0] OP_SLL   = 5'h07;
  localparam logic [4:0] OP_SRL   = 5'h08;
  localparam logic [4:0] OP_ROL   = 5'h09;
  localparam logic [4:0] OP_ROR   = 5'h0A;
  localparam logic [4:0] OP_CMPEQ = 5'h0B;
  localparam logic [4:0] OP_CMPLT = 5'h0C;
  localparam logic [4:0] OP_CMPGT = 5'h0D;
  localparam logic [4:0] OP_MUL   = 5'h0E;
  localparam logic [4:0] OP_SRA   = 5'h0F;

  // out_status = {zero, carry, neg, eq, lt, gt}
  localparam int ST_GT    = 0;
  localparam int ST_LT    = 1;
  localparam int ST_EQ    = 2;
  localparam int ST_NEG   = 3;
  localparam int ST_CARRY = 4;
  localparam int ST_ZERO  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier: WIDTH add/shift steps, done pulses
// WIDTH cycles after the start pulse.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic                r_busy;
  logic                r_done;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [2*WIDTH-1:0]  r_prod;

  // One step: conditionally add the multiplicand into the high half, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {s, p[WIDTH-1:1]};
  endfunction

  // The first step is folded into the load so the last step lands WIDTH-1 edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_prod <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(1);
        r_a    <= a;
        r_prod <= mul_step({{WIDTH{1'b0}}, b}, a);
      end else if (r_busy) begin
        r_prod <= mul_step(r_prod, r_a);
        r_cnt  <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; MUL is iterative, all other
// ops complete one cycle after acceptance.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [4:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [WIDTH-1:0]  out_hi,
  output logic [5:0]        out_status,
  output logic              out_err
);

  localparam int SHW = $clog2(WIDTH);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_mul_done;
  logic [2*WIDTH-1:0]  w_product;
  logic [SHW-1:0]      w_sh;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_rol;
  logic [WIDTH-1:0]    w_ror;
  logic [WIDTH-1:0]    w_res;
  logic [5:0]          w_status;
  logic                w_err;
  logic [5:0]          w_mul_status;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_result;
  logic [WIDTH-1:0]    r_hi;
  logic [5:0]          r_status;
  logic                r_err;

  assign w_is_mul = (in_op == OP_MUL);
  assign w_sh     = in_b[SHW-1:0];
  assign w_sum    = {1'b0, in_a} + {1'b0, in_b};

  // WIDTH is a power of two, so SHW-bit index arithmetic wraps modulo WIDTH.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    assign w_rol[gi] = in_a[SHW'(gi) - w_sh];
    assign w_ror[gi] = in_a[SHW'(gi) + w_sh];
  end

  always_comb begin
    w_res    = '0;
    w_status = '0;
    w_err    = 1'b0;
    case (in_op)
      OP_ADD: begin
        w_res              = w_sum[WIDTH-1:0];
        w_status[ST_CARRY] = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res            = in_a - in_b;
        w_status[ST_NEG] = (in_a < in_b);
      end
      OP_AND:   w_res = in_a & in_b;
      OP_OR:    w_res = in_a | in_b;
      OP_XOR:   w_res = in_a ^ in_b;
      OP_NOT:   w_res = ~in_a;
      OP_SLL:   w_res = in_a << w_sh;
      OP_SRL:   w_res = in_a >> w_sh;
      OP_ROL:   w_res = w_rol;
      OP_ROR:   w_res = w_ror;
      OP_SRA:   w_res = $signed(in_a) >>> w_sh;
      OP_CMPEQ: w_status[ST_EQ] = (in_a == in_b);
      OP_CMPLT: w_status[ST_LT] = (in_a < in_b);
      OP_CMPGT: w_status[ST_GT] = (in_a > in_b);
      OP_MUL:   w_res = '0;
      default:  w_err = 1'b1;
    endcase
    w_status[ST_ZERO] = (w_res == '0);
  end

  always_comb begin
    w_mul_status          = '0;
    w_mul_status[ST_ZERO] = (w_product == '0);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_accept && w_is_mul),
    .a       (in_a),
    .b       (in_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_EXEC: if (w_mul_done) w_state_next = S_DONE;
      S_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    w_accept = in_valid && w_in_ready;
    if (w_accept) w_state_next = w_is_mul ? S_EXEC : S_DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_hi        <= '0;
      r_status    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == S_DONE);
      if (w_accept && !w_is_mul) begin
        r_result <= w_res;
        r_hi     <= '0;
        r_status <= w_status;
        r_err    <= w_err;
      end else if (r_state == S_EXEC && w_mul_done) begin
        r_result <= w_product[WIDTH-1:0];
        r_hi     <= w_product[2*WIDTH-1:WIDTH];
        r_status <= w_mul_status;
        r_err    <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_hi     = r_hi;
  assign out_status = r_status;
  assign out_err    = r_err;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the team's 8-bit single-cycle ALU. It adds a configurable datapath width, a valid/ready handshake on both input and output, a zero flag, an arithmetic right shift and an iterative unsigned multiplier. It sits between an instruction sequencer (upstream) and a result/writeback stage (downstream) that may apply backpressure.

## Interface
- WIDTH, 8, datapath width; power of two, 4..64
- SHW, $clog2(WIDTH), localparam; shift/rotate amount width
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B; for shift/rotate ops only in_b[SHW-1:0] is used
- in_op  in  5  opcode
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  WIDTH  result; low half for MUL
- out_hi  out  WIDTH  high half of the MUL product; 0 for all other ops
- out_status  out  6  {zero, carry, neg, eq, lt, gt}
- out_err  out  1  illegal opcode flag

## Operation
- **Opcodes:** 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOT(a), 07 SLL, 08 SRL, 09 ROL, 0A ROR, 0B CMPEQ, 0C CMPLT, 0D CMPGT, 0E MUL, 0F SRA. All comparisons are unsigned.
- **ADD:** carry = bit WIDTH of a+b.
- **SUB:** neg = borrow, i.e. a<b; result = (a-b) mod 2^WIDTH.
- **Shifts and rotates:** amount = in_b[SHW-1:0]. ROL/ROR are modulo WIDTH. SRA replicates a[WIDTH-1].
- **Compare ops:** the compare ops set only their own flag; out_result = 0.
- **MUL:** {out_hi, out_result} = a*b (unsigned, 2·WIDTH bits). Computed by shift-add over WIDTH iterations.
- **zero flag:** set when out_result==0, and additionally out_hi==0 for MUL. Set for all legal ops, including compares.
- **Unused flags:** all flags not produced by the op are 0.
- **Illegal opcode** (00, 10–1F): out_result=0, out_hi=0, status=0 except zero=1, out_err=1. Completes as a single-cycle op.
- **FSM:**
  - IDLE: accept a request → EXEC for MUL, otherwise → DONE.
  - EXEC: iterate WIDTH cycles → DONE.
  - DONE: on out_ready, either go to IDLE, or accept the next request in the same cycle (→ EXEC or DONE).
- **in_ready** = (state==IDLE) || (state==DONE && out_ready). It is low throughout EXEC.
- **Operand capture:** operands and op are captured on the in_valid && in_ready edge. Later input changes do not affect an in-flight op.

## Timing
- **Reset values:** state IDLE; out_valid=0, out_result=0, out_hi=0, out_status=0, out_err=0. in_ready=1 while in IDLE. Inputs are ignored while reset_n is low.
- **Non-MUL latency:** accepted at edge N, out_valid high after edge N+1.
- **MUL latency:** accepted at edge N, out_valid high after edge N+WIDTH+1.
- **Holding results:** out_valid and all result outputs hold stable until an edge with out_ready=1. out_valid never drops without a handshake.
- **Throughput:** back-to-back non-MUL ops with out_ready held high give 1 result/cycle.
- **Simultaneous completion and acceptance:** a result handshake and a new request acceptance in the same DONE cycle are both honoured. The new result replaces the old on the next edge.
- **Reset mid-EXEC:** aborts the multiply; no result is produced.
- **Output stability:** outputs are registered. in_ready is the only output with a combinational path, from out_ready.

## Structure
- **Package alu_mc_pkg:** opcode localparams (OP_ADD..OP_SRA), status bit indices (ST_ZERO..ST_GT), and an FSM state enum.
- **Sub-module alu_mul_iter:** parametrised by WIDTH.
  - Interface: start, a, b → done, product[2·WIDTH-1:0].
  - Exactly WIDTH cycles from start to done.
- **Top level:** combinational op decode, flag generation, handshake FSM and output registers.

## Test plan
- **ADD carry, WIDTH=8:** ADD 0xF0+0x20 → result 0x10, status carry=1, zero=0, out_valid 1 cycle after accept.
- **SUB borrow and zero:** SUB 0x05-0x07 → result 0xFE, neg=1. SUB 0x33-0x33 → result 0x00, zero=1.
- **MUL, WIDTH=8:** MUL 0xFF·0xFF → out_hi 0xFE, out_result 0x01. out_valid exactly 9 cycles after accept; in_ready=0 during EXEC.
- **Rotates, WIDTH=16:** ROL 0x8001 by in_b=0x11 → 0x0003 (amount 1). SRA 0x8000 by 3 → 0xF000.
- **Backpressure:** hold out_ready=0 for 5 cycles after a result → outputs stable, in_ready=0. Then raise out_ready with a new request pending → both handshakes in one cycle; next result follows 1 cycle later.
- **Illegal op and reset abort:** op 0x1F → out_err=1, zero=1, result 0. Assert reset_n low during MUL EXEC → all outputs 0, no out_valid after release.
